// File: rtl/lock_pkg.sv
// Shared types and constants for the canal lock sequencer.
// Holds the state encoding, the command bus bit map and the safe idle command.
package lock_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEVEL1,
        S_OPEN1,
        S_DWELL1,
        S_CLOSE1,
        S_LEVEL2,
        S_OPEN2,
        S_DWELL2,
        S_CLOSE2,
        S_FAULT
    } state_t;

    typedef enum logic {
        DIR_ARR = 1'b0,
        DIR_DEP = 1'b1
    } dir_t;

    localparam int CMD_ARR   = 0;
    localparam int CMD_DEP   = 1;
    localparam int CMD_OUTER = 2;
    localparam int CMD_INNER = 3;
    localparam int CMD_INC   = 4;
    localparam int CMD_DEC   = 5;

    // Both ports closed, no water movement, no direction flagged.
    localparam logic [5:0] CMD_SAFE = 6'b001100;

endpackage

// File: rtl/level_match.sv
// Combinational water-level comparator with a +/-TOL window.
// Zero latency; 9-bit arithmetic so level + TOL never wraps.
module level_match #(
    parameter int TOL = 2
) (
    input  logic [7:0] level_i,
    input  logic [7:0] target_i,
    output logic       above_o,
    output logic       below_o,
    output logic       match_o
);

    localparam logic [8:0] TOL9 = 9'(TOL);

    logic [8:0] lvl_w;
    logic [8:0] tgt_w;

    assign lvl_w   = {1'b0, level_i};
    assign tgt_w   = {1'b0, target_i};
    assign below_o = (lvl_w + TOL9) < tgt_w;
    assign above_o = lvl_w > (tgt_w + TOL9);
    assign match_o = ~below_o & ~above_o;

endmodule

// File: rtl/lock_sequencer.sv
// Sequences one gondola passage at a time through the lock: level, open, dwell, close, twice.
// Requests are held as pending flags while busy; any wait state stuck for TIMEOUT_CYCLES latches FAULT until rst.
module lock_sequencer
    import lock_pkg::*;
#(
    parameter int TOL            = 2,
    parameter int DWELL_CYCLES   = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_arrive,
    input  logic       req_depart,
    input  logic [7:0] lock_water,
    input  logic [7:0] inner_water,
    input  logic [7:0] outer_water,
    input  logic       outer_closed,
    input  logic       inner_closed,
    output logic [5:0] cmd,
    output logic       busy,
    output logic       done,
    output logic       fault
);

    localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] DWELL_LAST = 16'(DWELL_CYCLES - 1);

    state_t      state_q, state_d;
    dir_t        dir_q, dir_d;
    logic [7:0]  tgt1_q, tgt1_d, tgt2_q, tgt2_d;
    logic        pend_a_q, pend_a_d, pend_d_q, pend_d_d;
    logic [15:0] wait_q, wait_d;
    logic        outer_q, outer_d, inner_q, inner_d;
    logic        done_q, done_d, fault_q, fault_d;

    logic [7:0]  tgt_sel;
    logic        lvl_above, lvl_below, lvl_match;
    logic        in_level, phase1, use_outer, port_closed, timed_state;

    assign tgt_sel = (state_q == S_LEVEL2) ? tgt2_q : tgt1_q;

    level_match #(.TOL(TOL)) u_level_match (
        .level_i  (lock_water),
        .target_i (tgt_sel),
        .above_o  (lvl_above),
        .below_o  (lvl_below),
        .match_o  (lvl_match)
    );

    assign in_level    = (state_q == S_LEVEL1) || (state_q == S_LEVEL2);
    assign phase1      = (state_q == S_OPEN1) || (state_q == S_DWELL1) || (state_q == S_CLOSE1);
    // Arrival uses the outer port first; departure uses it second.
    assign use_outer   = (phase1 == (dir_q == DIR_ARR));
    assign port_closed = use_outer ? outer_closed : inner_closed;
    assign timed_state = in_level || (state_q == S_OPEN1) || (state_q == S_OPEN2) ||
                         (state_q == S_CLOSE1) || (state_q == S_CLOSE2);

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        tgt1_d   = tgt1_q;
        tgt2_d   = tgt2_q;
        pend_a_d = pend_a_q | req_arrive;
        pend_d_d = pend_d_q | req_depart;
        done_d   = 1'b0;
        fault_d  = fault_q;
        outer_d  = 1'b1;
        inner_d  = 1'b1;
        wait_d   = wait_q;

        case (state_q)
            S_IDLE: begin
                if (pend_a_q) begin
                    state_d  = S_LEVEL1;
                    dir_d    = DIR_ARR;
                    tgt1_d   = outer_water;
                    tgt2_d   = inner_water;
                    pend_a_d = req_arrive;
                end else if (pend_d_q) begin
                    state_d  = S_LEVEL1;
                    dir_d    = DIR_DEP;
                    tgt1_d   = inner_water;
                    tgt2_d   = outer_water;
                    pend_d_d = req_depart;
                end
            end
            S_LEVEL1: if (lvl_match)             state_d = S_OPEN1;
            S_OPEN1:  if (!port_closed)          state_d = S_DWELL1;
            S_DWELL1: if (wait_q == DWELL_LAST)  state_d = S_CLOSE1;
            S_CLOSE1: if (port_closed)           state_d = S_LEVEL2;
            S_LEVEL2: if (lvl_match)             state_d = S_OPEN2;
            S_OPEN2:  if (!port_closed)          state_d = S_DWELL2;
            S_DWELL2: if (wait_q == DWELL_LAST)  state_d = S_CLOSE2;
            S_CLOSE2: begin
                if (port_closed) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            S_FAULT:  state_d = S_FAULT;
            default:  state_d = S_IDLE;
        endcase

        // A normal exit on the last allowed cycle still wins over the timeout.
        if (timed_state && (state_d == state_q) && (wait_q == TMO_LAST)) begin
            state_d = S_FAULT;
        end

        if (state_d == S_FAULT) begin
            fault_d  = 1'b1;
            pend_a_d = 1'b0;
            pend_d_d = 1'b0;
        end

        if (state_d != state_q) begin
            wait_d = '0;
        end else if (wait_q != 16'hFFFF) begin
            wait_d = wait_q + 16'd1;
        end

        if ((state_d == S_OPEN1) || (state_d == S_DWELL1)) begin
            if (dir_d == DIR_ARR) outer_d = 1'b0;
            else                  inner_d = 1'b0;
        end else if ((state_d == S_OPEN2) || (state_d == S_DWELL2)) begin
            if (dir_d == DIR_ARR) inner_d = 1'b0;
            else                  outer_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            dir_q    <= DIR_ARR;
            tgt1_q   <= '0;
            tgt2_q   <= '0;
            pend_a_q <= 1'b0;
            pend_d_q <= 1'b0;
            wait_q   <= '0;
            outer_q  <= 1'b1;
            inner_q  <= 1'b1;
            done_q   <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            tgt1_q   <= tgt1_d;
            tgt2_q   <= tgt2_d;
            pend_a_q <= pend_a_d;
            pend_d_q <= pend_d_d;
            wait_q   <= wait_d;
            outer_q  <= outer_d;
            inner_q  <= inner_d;
            done_q   <= done_d;
            fault_q  <= fault_d;
        end
    end

    assign busy  = (state_q != S_IDLE) && (state_q != S_FAULT);
    assign done  = done_q;
    assign fault = fault_q;

    always_comb begin
        cmd            = '0;
        cmd[CMD_ARR]   = busy && (dir_q == DIR_ARR);
        cmd[CMD_DEP]   = busy && (dir_q == DIR_DEP);
        cmd[CMD_OUTER] = outer_q;
        cmd[CMD_INNER] = inner_q;
        cmd[CMD_INC]   = in_level && lvl_below;
        cmd[CMD_DEC]   = in_level && lvl_above;
    end

endmodule

// File: doc/lock_sequencer.md
Name: lock_sequencer

Overview:
- Upstream control stage for the canal lock; drives the lock's 6-bit command bus.
- Accepts gondola arrive/depart requests and sequences each passage: level, open port, dwell, close, re-level, open the opposite port, dwell, close.
- Monitors lock water level and port status feedback; faults on timeout.
- Arrive = enter by the outer port, leave by the inner port. Depart = the reverse.

Parameters:
- TOL, 2: level-match tolerance in water units; match when |lock_water - target| <= TOL.
- DWELL_CYCLES, 16: cycles a port is held open for the gondola to pass (minimum 1).
- TIMEOUT_CYCLES, 1024: maximum cycles allowed in any wait state before FAULT.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req_arrive  in  1  one-cycle request pulse for an arrival.
- req_depart  in  1  one-cycle request pulse for a departure.
- lock_water  in  8  current lock level (unsigned).
- inner_water  in  8  inner (lagoon) level.
- outer_water  in  8  outer (sea) level.
- outer_closed  in  1  outer port status; 1 = closed.
- inner_closed  in  1  inner port status; 1 = closed.
- cmd  out  6  lock command bus: [0] arriving, [1] departing, [2] outer port (1 = closed), [3] inner port (1 = closed), [4] increase water, [5] decrease water.
- busy  out  1  passage in progress.
- done  out  1  one-cycle pulse when a passage completes.
- fault  out  1  sticky timeout flag.

Behaviour:
- Reset (asynchronous): state IDLE, cmd = 6'b001100, busy = 0, done = 0, fault = 0, pending flags cleared, counters cleared.
- Pending flags: pend_a and pend_d are set by their request pulses and cleared when the passage is accepted. A request arriving while busy is held, not lost.
- States: IDLE, LEVEL1, OPEN1, DWELL1, CLOSE1, LEVEL2, OPEN2, DWELL2, CLOSE2, FAULT.
- IDLE:
  - If pend_a: accept the arrival (arrival wins a tie). dir = ARR, tgt1 = outer_water, tgt2 = inner_water.
  - Else if pend_d: accept the departure. dir = DEP, tgt1 = inner_water, tgt2 = outer_water.
  - Targets are sampled at acceptance. On acceptance: go to LEVEL1, busy = 1.
- LEVELn:
  - cmd[4] = (lock_water + TOL < tgt) and cmd[5] = (lock_water > tgt + TOL). Both are combinational decodes of state and lock_water, and are never 1 together.
  - Use 9-bit arithmetic so lock_water + TOL cannot wrap.
  - On match, go to OPENn next cycle.
- OPENn: drive the first port open (0) for OPEN1, the second port for OPEN2. Arrival: outer then inner; departure: inner then outer. Leave when that port's status reads 0; go to DWELLn.
- DWELLn: hold the port open for DWELL_CYCLES, then go to CLOSEn.
- CLOSEn: drive the port closed (1). When status reads 1, CLOSE1 goes to LEVEL2 and CLOSE2 goes to IDLE with done = 1 for one cycle and busy = 0.
- cmd[0] = busy & dir==ARR; cmd[1] = busy & dir==DEP.
- Port command bits (cmd[2], cmd[3]) are registered and change on the cycle after the state transition.
- In all non-LEVEL states cmd[4] = cmd[5] = 0.
- Timeout:
  - A 16-bit wait counter resets on every state change.
  - If any LEVEL, OPEN or CLOSE state reaches TIMEOUT_CYCLES, go to FAULT.
  - FAULT: fault = 1, cmd = 6'b001100, busy = 0, pending flags cleared. Exit is by rst only.
- Requests arriving in FAULT are ignored.
- Both ports closed is the only legal state during LEVEL; the sequencer never commands both ports open.

Decomposition:
- Shared package lock_pkg:
  - state enum;
  - cmd bit indices (CMD_ARR = 0, CMD_DEP = 1, CMD_OUTER = 2, CMD_INNER = 3, CMD_INC = 4, CMD_DEC = 5);
  - CMD_SAFE = 6'b001100.
- One sub-module, level_match: combinational 9-bit compare producing above, below and match flags for a given TOL.

Test Plan:
- Reset with rst pulsed mid-clock -> cmd = 6'b001100, busy = 0 and fault = 0 immediately, without waiting for a clock edge.
- Arrival against a stub lock model (lock_water = 52, +2 per increase cycle, -1 per decrease cycle, ports follow the command 1 cycle later; inner = 49, outer = 73):
  - cmd[4] high for 10 cycles, lock stops at 72;
  - outer opens, held 16 cycles, closes;
  - cmd[5] high for 21 cycles, lock stops at 51;
  - inner opens and closes; done pulses once, cmd[0] = 1 throughout.
- Departure starting at lock 51 -> already matched to inner, so no water commands in LEVEL1; inner, fill to 73 ± 2, outer sequence; cmd[1] = 1.
- req_arrive and req_depart in the same cycle -> arrival runs first; departure starts on the cycle after done, with no new pulse.
- Stub never opens the outer port -> fault = 1 after 1024 cycles in OPEN1, cmd = 6'b001100; a later req_arrive is ignored until rst.
- rst asserted during LEVEL2 while cmd[5] = 1 -> cmd[5] drops asynchronously, state IDLE, pending flags cleared.
